// File: rtl/thread_cmd_arbiter.sv
// rtl/thread_cmd_arbiter.sv - round-robin arbiter funnelling per-requester thread commands to one manager
module thread_cmd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RSP_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [4*N_REQ-1:0]       req_cmd,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [DATA_W*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [1:0]               rsp_rslt,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [3:0]               thrd_cmd,
  output logic [ADDR_W-1:0]        thrd_addr,
  output logic [DATA_W-1:0]        thrd_data,
  input  logic [1:0]               thrd_rslt,
  input  logic [DATA_W-1:0]        thrd_data_in,
  output logic                     busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win;
  logic [3:0]        cnt;
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        rslt_q;
  logic [DATA_W-1:0] rdata_q;

  logic [3:0]        cmd_arr  [N_REQ];
  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_unpack
      assign cmd_arr[g]  = req_cmd[4*g +: 4];
      assign addr_arr[g] = req_addr[ADDR_W*g +: ADDR_W];
      assign data_arr[g] = req_data[DATA_W*g +: DATA_W];
    end
  endgenerate

  // Scan starts at ptr so the requester just served drops to lowest priority.
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!grant_found && req[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      win     <= '0;
      cnt     <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rslt_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            win     <= grant_idx;
            cmd_q   <= cmd_arr[grant_idx];
            addr_q  <= addr_arr[grant_idx];
            data_q  <= data_arr[grant_idx];
            rslt_q  <= '0;
            rdata_q <= '0;
            // A null command never reaches the manager; it is acked with a zero result.
            state   <= (cmd_arr[grant_idx] == 4'd0) ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= 4'(RSP_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rslt_q  <= thrd_rslt;
            rdata_q <= thrd_data_in;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          ptr   <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign thrd_cmd  = (state == S_ISSUE) ? cmd_q : 4'd0;
  assign thrd_addr = addr_q;
  assign thrd_data = data_q;
  assign busy      = (state != S_IDLE);
  assign rsp_rslt  = (state == S_RESP) ? rslt_q : 2'd0;
  assign rsp_data  = (state == S_RESP) ? rdata_q : '0;

  always_comb begin
    ack = '0;
    if (state == S_RESP) ack[win] = 1'b1;
  end

endmodule

// File: tb/tb_thread_cmd_arbiter.sv
// tb/tb_thread_cmd_arbiter.sv - directed self-checking bench for thread_cmd_arbiter
module tb_thread_cmd_arbiter;

  localparam logic [3:0] CMD_RUN  = 4'h1;
  localparam logic [3:0] CMD_STOP = 4'h2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   req4 = '0;
  logic [15:0]  req_cmd = '0;
  logic [127:0] req_addr = '0;
  logic [127:0] req_data = '0;
  logic [1:0]   thrd_rslt = '0;
  logic [31:0]  thrd_data_in = '0;

  logic [3:0]   ack, ack4;
  logic [1:0]   rsp_rslt, rsp_rslt4;
  logic [31:0]  rsp_data, rsp_data4;
  logic [3:0]   thrd_cmd, thrd_cmd4;
  logic [31:0]  thrd_addr, thrd_addr4;
  logic [31:0]  thrd_data, thrd_data4;
  logic         busy, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  thread_cmd_arbiter #(.N_REQ(4), .DATA_W(32), .ADDR_W(32), .RSP_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data), .ack(ack), .rsp_rslt(rsp_rslt), .rsp_data(rsp_data),
    .thrd_cmd(thrd_cmd), .thrd_addr(thrd_addr), .thrd_data(thrd_data),
    .thrd_rslt(thrd_rslt), .thrd_data_in(thrd_data_in), .busy(busy)
  );

  thread_cmd_arbiter #(.N_REQ(4), .DATA_W(32), .ADDR_W(32), .RSP_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data), .ack(ack4), .rsp_rslt(rsp_rslt4), .rsp_data(rsp_data4),
    .thrd_cmd(thrd_cmd4), .thrd_addr(thrd_addr4), .thrd_data(thrd_data4),
    .thrd_rslt(thrd_rslt), .thrd_data_in(thrd_data_in), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until an ack is seen (bounded); reports cycles taken and manager-side activity.
  task automatic wait_ack(input bit sel, output logic [3:0] a, output int cyc,
                          output int ncmd, output int nbusy, output logic [3:0] lastcmd);
    a = '0; cyc = 0; ncmd = 0; nbusy = 0; lastcmd = '0;
    while (a == 4'd0 && cyc < 40) begin
      step();
      cyc++;
      if ((sel ? thrd_cmd4 : thrd_cmd) != 4'd0) begin
        ncmd++;
        lastcmd = sel ? thrd_cmd4 : thrd_cmd;
      end
      if (sel ? busy4 : busy) nbusy++;
      a = sel ? ack4 : ack;
    end
  endtask

  logic [3:0] a, lc;
  int cyc, ncmd, nbusy;
  logic [3:0] exp_order [5];

  initial begin
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

    // Reset state
    #1;
    chk("rst_ack", ack, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_thrd_cmd", thrd_cmd, 4'd0);
    chk("rst_thrd_addr", thrd_addr, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    step(); step();
    rst = 1'b0;

    // Single RUN request, latency 1
    req = 4'b0001; req_cmd = {12'h0, CMD_RUN};
    req_addr[31:0] = 32'h100; req_data[31:0] = 32'h5;
    thrd_rslt = 2'd1; thrd_data_in = 32'hFFFF_FFFF;
    wait_ack(1'b0, a, cyc, ncmd, nbusy, lc);
    chk("t1_ack", a, 4'b0001);
    chk("t1_latency", cyc, 3);
    chk("t1_cmd_cycles", ncmd, 1);
    chk("t1_cmd_value", lc, CMD_RUN);
    chk("t1_rsp_rslt", rsp_rslt, 2'd1);
    chk("t1_rsp_data", rsp_data, 32'hFFFF_FFFF);
    req = '0;
    step();
    chk("t1_ack_clear", ack, 4'd0);
    chk("t1_rsp_clear", rsp_data, 32'd0);
    chk("t1_addr_hold", thrd_addr, 32'h100);
    chk("t1_data_hold", thrd_data, 32'h5);

    // All four requesting continuously from ptr=0
    rst = 1'b1; step(); rst = 1'b0;
    req_cmd = {4{CMD_RUN}};
    req_addr = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    thrd_rslt = 2'd2; thrd_data_in = 32'hA5A5_0000;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(1'b0, a, cyc, ncmd, nbusy, lc);
      chk($sformatf("t2_ack%0d", k), a, exp_order[k]);
      chk($sformatf("t2_gap%0d", k), cyc, (k == 0) ? 3 : 4);
      chk($sformatf("t2_addr%0d", k), thrd_addr, 32'h1000 + (k % 4));
      chk($sformatf("t2_rslt%0d", k), rsp_rslt, 2'd2);
    end
    req = '0;
    step();

    // Null command from requester 1 (ptr now 1)
    req_cmd = '0; thrd_rslt = 2'd3; thrd_data_in = 32'h1234;
    req = 4'b0010;
    wait_ack(1'b0, a, cyc, ncmd, nbusy, lc);
    chk("t3_ack", a, 4'b0010);
    chk("t3_latency", cyc, 1);
    chk("t3_no_cmd", ncmd, 0);
    chk("t3_rsp_rslt", rsp_rslt, 2'd0);
    chk("t3_rsp_data", rsp_data, 32'd0);
    req = '0;
    step();

    // STOP from requester 2 on the latency-4 instance
    req_cmd = {4'h0, CMD_STOP, 8'h0};
    req4 = 4'b0100;
    wait_ack(1'b1, a, cyc, ncmd, nbusy, lc);
    chk("t4_ack", a, 4'b0100);
    chk("t4_cmd_cycles", ncmd, 1);
    chk("t4_cmd_value", lc, CMD_STOP);
    chk("t4_busy_cycles", nbusy, 6);
    chk("t4_latency", cyc, 6);
    req4 = '0;
    step();
    chk("t4_busy_clear", busy4, 1'b0);

    // Reset during WAIT abandons the transaction
    req_cmd = {CMD_RUN, 12'h0}; req_addr[127:96] = 32'h3300; req_data[127:96] = 32'h33;
    req = 4'b1000;
    step();
    chk("t5_issue_cmd", thrd_cmd, CMD_RUN);
    step();
    chk("t5_wait_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_addr", thrd_addr, 32'd0);
    chk("t5_async_data", thrd_data, 32'd0);
    chk("t5_async_cmd", thrd_cmd, 4'd0);
    step();
    chk("t5_no_ack", ack, 4'd0);
    rst = 1'b0;
    wait_ack(1'b0, a, cyc, ncmd, nbusy, lc);
    chk("t5_regrant_ack", a, 4'b1000);
    chk("t5_regrant_latency", cyc, 3);
    chk("t5_regrant_addr", thrd_addr, 32'h3300);
    req = '0;
    step();

    // Requester 0 drops req right after grant (ptr now 0)
    req_cmd = {4{CMD_RUN}};
    req = 4'b0101;
    step();
    req = 4'b0100;
    wait_ack(1'b0, a, cyc, ncmd, nbusy, lc);
    chk("t6_ack0", a, 4'b0001);
    chk("t6_ack0_latency", cyc, 2);
    wait_ack(1'b0, a, cyc, ncmd, nbusy, lc);
    chk("t6_ack2", a, 4'b0100);
    chk("t6_ack2_gap", cyc, 4);
    req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
